// File: rtl/calc_result_unit_pkg.sv
// calc_pkg: shared widths, state encoding and scancode-to-digit decode for calc_result_unit
package calc_pkg;
    localparam int RES_W = 14;
    localparam int BCD_N = 4;
    localparam int CNT_W = $clog2(RES_W);
    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;
    localparam logic [7:0] KP_CODES [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    localparam logic [7:0] MR_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    // Returns {err, digit}; an unknown code yields digit 0 with err set.
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        logic [4:0] res;
        res = 5'b1_0000;
        for (int i = 0; i < 10; i++)
            if (code == KP_CODES[i] || code == MR_CODES[i]) res = {1'b0, 4'(i)};
        return res;
    endfunction
endpackage

// File: rtl/calc_result_unit_if.sv
// calc_result_unit_if: keypad operands/operators in, BCD result and status out
interface calc_result_unit_if;
    logic [8:0] val_1, val_2, val_3, val_4;
    logic       add_enable, sub_enable, mul_enable, result_enable;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       neg, result_valid, busy, err;
    modport master (
        output val_1, val_2, val_3, val_4, add_enable, sub_enable, mul_enable, result_enable,
        input  bcd3, bcd2, bcd1, bcd0, neg, result_valid, busy, err
    );
    modport slave (
        input  val_1, val_2, val_3, val_4, add_enable, sub_enable, mul_enable, result_enable,
        output bcd3, bcd2, bcd1, bcd0, neg, result_valid, busy, err
    );
endinterface

// File: rtl/calc_result_unit_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one add-3/shift iteration per cycle, RES_W iterations
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [RES_W-1:0]   i_bin,
    output logic [4*BCD_N-1:0] o_bcd,
    output logic               o_busy,
    output logic               o_done
);
    localparam int SH_W = 4*BCD_N + RES_W;
    logic [SH_W-1:0]  r_sh, w_adj;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy, r_done;
    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < BCD_N; i++)
            if (r_sh[RES_W+4*i +: 4] >= 4'd5) w_adj[RES_W+4*i +: 4] = r_sh[RES_W+4*i +: 4] + 4'd3;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_sh   <= SH_W'(i_bin);
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sh  <= {w_adj[SH_W-2:0], 1'b0};
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(RES_W-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end
    assign o_bcd  = r_sh[SH_W-1 -: 4*BCD_N];
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule

// File: rtl/calc_result_unit.sv
// calc_result_unit: decodes two 2-digit operands, computes +,-,* and converts the magnitude to BCD
module calc_result_unit
    import calc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    calc_result_unit_if.slave  bus
);
    state_t             r_state;
    logic               r_re_d, r_dec_err;
    logic [3:0]         r_d1, r_d2, r_d3, r_d4;
    logic [2:0]         r_op;
    logic [4*BCD_N-1:0] r_bcd, w_bcd;
    logic               r_neg, r_valid, r_busy, r_err;
    logic [4:0]         w_dec1, w_dec2, w_dec3, w_dec4;
    logic [RES_W-1:0]   w_a, w_b, w_mag;
    logic               w_start, w_err, w_neg, w_cv_start, w_abort, w_cv_busy, w_done;
    assign w_dec1 = decode_digit(bus.val_1[7:0]);
    assign w_dec2 = decode_digit(bus.val_2[7:0]);
    assign w_dec3 = decode_digit(bus.val_3[7:0]);
    assign w_dec4 = decode_digit(bus.val_4[7:0]);
    assign w_start = bus.result_enable && !r_re_d;
    assign w_abort = !bus.result_enable && (r_state == LOAD || r_state == CONV);
    assign w_cv_start = bus.result_enable && r_state == LOAD;
    // Arithmetic works only from the operands latched at the start edge.
    assign w_a = RES_W'(r_d1) * RES_W'(10) + RES_W'(r_d2);
    assign w_b = RES_W'(r_d3) * RES_W'(10) + RES_W'(r_d4);
    assign w_err = r_dec_err || !$onehot(r_op);
    assign w_neg = !w_err && r_op[1] && (w_a < w_b);
    assign w_mag = w_err ? '0 :
                   r_op[2] ? w_a + w_b :
                   r_op[1] ? (w_a >= w_b ? w_a - w_b : w_b - w_a) :
                   w_a * w_b;
    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_cv_start),
        .i_abort (w_abort),
        .i_bin   (w_mag),
        .o_bcd   (w_bcd),
        .o_busy  (w_cv_busy),
        .o_done  (w_done)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_re_d    <= 1'b0;
            r_dec_err <= 1'b0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_d4      <= '0;
            r_op      <= '0;
            r_bcd     <= '0;
            r_neg     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_re_d <= bus.result_enable;
            case (r_state)
                IDLE: if (w_start) begin
                    r_state   <= LOAD;
                    r_d1      <= w_dec1[3:0];
                    r_d2      <= w_dec2[3:0];
                    r_d3      <= w_dec3[3:0];
                    r_d4      <= w_dec4[3:0];
                    r_dec_err <= w_dec1[4] | w_dec2[4] | w_dec3[4] | w_dec4[4];
                    r_op      <= {bus.add_enable, bus.sub_enable, bus.mul_enable};
                end
                LOAD: if (!bus.result_enable) begin
                    r_state <= IDLE;
                end else begin
                    r_state <= CONV;
                    r_busy  <= 1'b1;
                    r_err   <= w_err;
                end
                CONV: if (!bus.result_enable) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end else if (w_done && !w_cv_busy) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_bcd   <= w_bcd;
                    r_neg   <= w_neg;
                end
                DONE: if (!bus.result_enable) begin
                    r_state <= IDLE;
                    r_bcd   <= '0;
                    r_neg   <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end
    assign bus.bcd3         = r_bcd[15:12];
    assign bus.bcd2         = r_bcd[11:8];
    assign bus.bcd1         = r_bcd[7:4];
    assign bus.bcd0         = r_bcd[3:0];
    assign bus.neg          = r_neg;
    assign bus.result_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.err          = r_err;
endmodule
